pipelined_shifter: RTL and testbench
====================================

# pipelined_shifter

Parametrised, pipelined barrel shifter for the datapath, succeeding the 16-bit combinational left/right shifter. Supports logical, arithmetic and rotate shifts at any power-of-two width. One decomposed shift stage per shift-amount bit, each registered, with valid/ready flow control and bubble collapse. Sits between the register-read operands and the ALU result mux. The pipeline stalls cleanly under writeback backpressure.

## Interface
- WIDTH, 16, data width; power of two, ≥ 4
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand presented
- in_ready  out  1  stage 0 can accept this cycle
- in_data  in  WIDTH  value to shift
- in_shamt  in  SHAMT_W  shift amount, 0..WIDTH-1
- in_mode  in  3  operation code (see Operation)
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  shifted result
- out_zero  out  1  out_data == 0
- out_err  out  1  in_mode was a reserved code

## Operation
- Mode codes:
  - 3'b000 SLL, logical left.
  - 3'b001 SRL, logical right.
  - 3'b010 SRA, arithmetic right; sign bit replicated.
  - 3'b011 ROL, rotate left.
  - 3'b100 ROR, rotate right.
  - 3'b101–3'b111 reserved: data passes unchanged, err=1.
- Pipeline has SHAMT_W stages. Stage k conditionally shifts by 2^k when shamt bit k is 1.
- Each stage register holds: valid, data, mode, err, and the remaining shamt bits.
- Stage 0 applies shamt bit 0 to in_data on acceptance. Stage k applies bit k to stage k-1 output.
- Fill bits: zeros for SLL/SRL; original MSB for SRA, carried down the stages; wrapped bits for ROL/ROR.
- Shift by 0 passes data unchanged in all non-reserved modes.
- out_zero is computed combinationally from the last stage register.
- Transfer on a port occurs when valid && ready are both high in the same cycle.
- Per-stage advance rule: stage k loads when !valid[k] || ready[k+1]. The last stage uses out_ready as ready[k+1].
- in_ready = !valid[0] || ready[1]. Bubbles collapse; there is no global stall.
- Order is preserved; no result is dropped or duplicated.

## Timing
- Reset (async assert): every stage valid clears immediately, so out_valid=0 with no clock needed.
  - Data regs reset to 0, so out_data=0, out_zero=1, out_err=0.
  - in_ready=1 from the first cycle after rst_n deasserts.
  - Reset mid-operation discards all in-flight results.
- Latency: an operand accepted at edge N appears with out_valid=1 after edge N+SHAMT_W-1, i.e. SHAMT_W register stages. This is 4 for WIDTH=16.
- Throughput: 1 result/cycle when out_ready is held high.
- Capacity: SHAMT_W results. With out_ready low, in_ready falls only once every stage is valid.
- Simultaneous accept and emit on a full pipeline: all stages advance; in_ready stays 1.
- out_* outputs are stable while out_valid && !out_ready.
- in_* inputs are ignored when in_valid=0 or in_ready=0.

## Structure
- shifter_pkg holds:
  - mode localparams SH_SLL, SH_SRL, SH_SRA, SH_ROL, SH_ROR;
  - a function is_reserved(mode).
- Sub-module shift_stage, parameterised by WIDTH and STAGE index k, contains:
  - the combinational 2^k shift/rotate with fill selection;
  - the stage register with its valid/ready logic.
- Top level generates SHAMT_W shift_stage instances and the out_zero reduction.

## Test plan
- SLL 0x8001 by 1 → out_data 0x0002 exactly 4 cycles after acceptance; SLL 0x00FF by 8 → 0xFF00.
- SRA 0x8000 by 15 → 0xFFFF. SRL 0x8000 by 15 → 0x0001. SRA 0x7FFF by 3 → 0x0FFF.
- ROL 0x8001 by 4 → 0x0018. ROR 0x0001 by 1 → 0x8000. ROR 0x1234 by 0 → 0x1234. SLL 0x0000 by 5 → out_zero=1.
- Reserved mode 3'b111, 0x1234 by 5 → out_data 0x1234, out_err=1; the next SLL op has out_err=0.
- Backpressure, part 1: hold out_ready=0 and stream 6 ops → exactly 4 are accepted, then in_ready=0.
- Backpressure, part 2: raise out_ready → all 6 emerge in order at 1/cycle with correct values.
- Random bubbles on in_valid/out_ready → results match the reference model in order.
- Reset mid-op: pull rst_n low with 3 ops in flight → out_valid=0 before the next edge. After release, none of the 3 ops ever emerge, in_ready=1, and the next op completes with 4-cycle latency.

Source files
------------

// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
//   Shared definitions for the pipelined barrel shifter: operation codes,
//   the mode field width and the reserved-code decoder.
// -----------------------------------------------------------------------------
package shifter_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] SH_SLL = 3'b000;  // logical left
    localparam logic [MODE_W-1:0] SH_SRL = 3'b001;  // logical right
    localparam logic [MODE_W-1:0] SH_SRA = 3'b010;  // arithmetic right
    localparam logic [MODE_W-1:0] SH_ROL = 3'b011;  // rotate left
    localparam logic [MODE_W-1:0] SH_ROR = 3'b100;  // rotate right

    // Codes above SH_ROR (3'b101..3'b111) are reserved: data passes through
    // untouched and the result is flagged with err.
    function automatic logic is_reserved(input logic [MODE_W-1:0] mode);
        return (mode > SH_ROR);
    endfunction

endpackage

// File: rtl/pipelined_shifter_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
//   One stage of the pipelined barrel shifter. Conditionally shifts or rotates
//   the incoming operand by 2**STAGE when shift-amount bit STAGE is set, then
//   registers the result together with valid, mode, err and the shift amount
//   so later stages can apply their own bit.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      upstream handshake (in_ready = !valid_q || out_ready)
//   in_data, in_mode,
//   in_err, in_shamt         operand payload from the previous stage
//   out_valid / out_ready    downstream handshake
//   out_data, out_mode,
//   out_err, out_shamt       registered payload
// -----------------------------------------------------------------------------
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4,
    parameter int STAGE   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [MODE_W-1:0]  in_mode,
    input  logic               in_err,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [MODE_W-1:0]  out_mode,
    output logic               out_err,
    output logic [SHAMT_W-1:0] out_shamt
);

    localparam int SHIFT = 1 << STAGE;

    logic [WIDTH-1:0]   shifted;
    logic               load;

    logic               valid_d, valid_q;
    logic [WIDTH-1:0]   data_d,  data_q;
    logic [MODE_W-1:0]  mode_d,  mode_q;
    logic               err_d,   err_q;
    logic [SHAMT_W-1:0] shamt_d, shamt_q;

    // Shift/rotate by this stage's fixed distance. For SRA the MSB is still the
    // original sign bit after every earlier arithmetic stage, so replicating the
    // current MSB carries the operand's sign down the pipe. Reserved modes fall
    // into the default arm and pass through unchanged.
    always_comb begin
        // NOTE: default assignment first so every path writes 'shifted'; without
        // it the incomplete case would infer a latch.
        shifted = in_data;
        if (in_shamt[STAGE]) begin
            case (in_mode)
                SH_SLL:  shifted = in_data << SHIFT;
                SH_SRL:  shifted = in_data >> SHIFT;
                SH_SRA:  shifted = WIDTH'($signed(in_data) >>> SHIFT);
                SH_ROL:  shifted = (in_data << SHIFT) | (in_data >> (WIDTH - SHIFT));
                SH_ROR:  shifted = (in_data >> SHIFT) | (in_data << (WIDTH - SHIFT));
                default: shifted = in_data;
            endcase
        end
    end

    // Stage advances when it is empty or its content is leaving this cycle;
    // this is what lets bubbles collapse without a global stall.
    assign load     = !valid_q || out_ready;
    assign in_ready = load;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        mode_d  = mode_q;
        err_d   = err_q;
        shamt_d = shamt_q;
        if (load) begin
            valid_d = in_valid;
            // Payload only moves with a real operand so a bubble leaves the
            // previous (already consumed) value in place.
            if (in_valid) begin
                data_d  = shifted;
                mode_d  = in_mode;
                err_d   = in_err;
                shamt_d = in_shamt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mode_q  <= '0;
            err_q   <= 1'b0;
            shamt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the values
            // its neighbour held before this edge.
            valid_q <= valid_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            shamt_q <= shamt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_mode  = mode_q;
    assign out_err   = err_q;
    assign out_shamt = shamt_q;

endmodule

// File: rtl/pipelined_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_shifter
//   Parametrised pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR). One registered
//   stage per shift-amount bit; stage k shifts by 2**k. Valid/ready flow control
//   with per-stage advance, so bubbles collapse and backpressure stalls only the
//   stages that are full.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      operand handshake
//   in_data                  value to shift
//   in_shamt                 shift amount 0..WIDTH-1
//   in_mode                  operation code (see shifter_pkg)
//   out_valid / out_ready    result handshake
//   out_data                 shifted result
//   out_zero                 out_data == 0
//   out_err                  operand carried a reserved mode code
// -----------------------------------------------------------------------------
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH   = 16,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [MODE_W-1:0]  in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero,
    output logic               out_err
);

    // Chain index k is the input of stage k; index SHAMT_W is the last
    // stage's registered output.
    logic [SHAMT_W:0]                valid_c;
    logic [SHAMT_W:0]                ready_c;
    logic [SHAMT_W:0]                err_c;
    logic [SHAMT_W:0][WIDTH-1:0]     data_c;
    logic [SHAMT_W:0][MODE_W-1:0]    mode_c;
    logic [SHAMT_W:0][SHAMT_W-1:0]   shamt_c;

    assign valid_c[0] = in_valid;
    assign data_c[0]  = in_data;
    assign mode_c[0]  = in_mode;
    assign err_c[0]   = is_reserved(in_mode);
    assign shamt_c[0] = in_shamt;
    assign in_ready   = ready_c[0];

    assign ready_c[SHAMT_W] = out_ready;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        shift_stage #(
            .WIDTH   (WIDTH),
            .SHAMT_W (SHAMT_W),
            .STAGE   (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (valid_c[k]),
            .in_ready  (ready_c[k]),
            .in_data   (data_c[k]),
            .in_mode   (mode_c[k]),
            .in_err    (err_c[k]),
            .in_shamt  (shamt_c[k]),
            .out_valid (valid_c[k+1]),
            .out_ready (ready_c[k+1]),
            .out_data  (data_c[k+1]),
            .out_mode  (mode_c[k+1]),
            .out_err   (err_c[k+1]),
            .out_shamt (shamt_c[k+1])
        );
    end

    assign out_valid = valid_c[SHAMT_W];
    assign out_data  = data_c[SHAMT_W];
    assign out_err   = err_c[SHAMT_W];
    assign out_zero  = ~|data_c[SHAMT_W];

    // The last stage's mode and shift amount have no consumer.
    logic unused_tail;
    assign unused_tail = ^{mode_c[SHAMT_W], shamt_c[SHAMT_W]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// -----------------------------------------------------------------------------
// tb_pipelined_shifter
//   Self-checking bench for pipelined_shifter (WIDTH=16): directed vector
//   table, backpressure fill/drain, random bubbles against a reference model,
//   and reset while operands are in flight.
// -----------------------------------------------------------------------------
module tb_pipelined_shifter;

    localparam int W  = 16;
    localparam int SW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [SW-1:0] in_shamt;
    logic [2:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_zero;
    logic          out_err;

    pipelined_shifter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    typedef struct {
        logic [2:0]    mode;
        logic [W-1:0]  data;
        logic [SW-1:0] shamt;
        logic [W-1:0]  exp_data;
        logic          exp_err;
    } vec_t;

    exp_t         exp_q[$];
    int           out_cnt   = 0;
    bit           prev_hold = 1'b0;
    logic [W-1:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: whole-amount shift straight from the operation definitions.
    function automatic logic [W:0] ref_shift(input logic [2:0] m, input logic [W-1:0] d,
                                             input logic [SW-1:0] s);
        int           n;
        int           v;
        logic [W-1:0] r;
        n = int'(s);
        r = d;
        case (m)
            3'd0: r = W'(32'(d) * (1 << n));
            3'd1: r = W'(32'(d) / (1 << n));
            3'd2: begin v = $signed(d); r = W'(v >>> n); end
            3'd3: for (int i = 0; i < W; i++) r[(i + n) % W] = d[i];
            3'd4: for (int i = 0; i < W; i++) r[i] = d[(i + n) % W];
            default: return {1'b1, d};
        endcase
        return {1'b0, r};
    endfunction

    // One clock: sample at the falling edge, score both handshakes, then
    // return just after the rising edge so the caller can drive new inputs.
    task automatic cycle(output bit acc);
        exp_t       e;
        logic [W:0] r;
        @(negedge clk);
        if (prev_hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got 0x%0h with no result outstanding", out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_err", out_err, e.err);
                check("out_zero", out_zero, e.data == 0);
            end
        end
        acc = in_valid && in_ready;
        if (acc) begin
            r = ref_shift(in_mode, in_data, in_shamt);
            e.data = r[W-1:0];
            e.err  = r[W];
            exp_q.push_back(e);
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_op();
        in_data  = W'($urandom);
        in_shamt = SW'($urandom_range(0, W - 1));
        in_mode  = 3'($urandom_range(0, 5));
    endtask

    // Single operand into an empty pipe with out_ready high; reports the
    // result and the number of rising edges from acceptance to out_valid.
    task automatic run_one(input logic [2:0] m, input logic [W-1:0] d, input logic [SW-1:0] s,
                           output logic [W-1:0] od, output logic oe, output logic oz,
                           output int lat);
        in_mode   = m;
        in_data   = d;
        in_shamt  = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("accept_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (lat <= 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
        od = out_data;
        oe = out_err;
        oz = out_zero;
        @(posedge clk);
        #1;
        prev_hold = 1'b0;
    endtask

    vec_t vecs [15];

    initial begin
        bit           acc;
        int           idx;
        int           n;
        int           lat;
        int           base;
        logic [W-1:0] od;
        logic         oe;
        logic         oz;
        logic [2:0]   bp_mode  [6];
        logic [W-1:0] bp_data  [6];
        logic [SW-1:0] bp_shamt[6];

        vecs[0]  = '{3'd0, 16'h8001,  4'd1, 16'h0002, 1'b0};
        vecs[1]  = '{3'd0, 16'h00FF,  4'd8, 16'hFF00, 1'b0};
        vecs[2]  = '{3'd2, 16'h8000, 4'd15, 16'hFFFF, 1'b0};
        vecs[3]  = '{3'd1, 16'h8000, 4'd15, 16'h0001, 1'b0};
        vecs[4]  = '{3'd2, 16'h7FFF,  4'd3, 16'h0FFF, 1'b0};
        vecs[5]  = '{3'd3, 16'h8001,  4'd4, 16'h0018, 1'b0};
        vecs[6]  = '{3'd4, 16'h0001,  4'd1, 16'h8000, 1'b0};
        vecs[7]  = '{3'd4, 16'h1234,  4'd0, 16'h1234, 1'b0};
        vecs[8]  = '{3'd0, 16'h0000,  4'd5, 16'h0000, 1'b0};
        vecs[9]  = '{3'd7, 16'h1234,  4'd5, 16'h1234, 1'b1};
        vecs[10] = '{3'd0, 16'h0001, 4'd15, 16'h8000, 1'b0};
        vecs[11] = '{3'd3, 16'h1234, 4'd15, 16'h091A, 1'b0};
        vecs[12] = '{3'd2, 16'h8001,  4'd0, 16'h8001, 1'b0};
        vecs[13] = '{3'd5, 16'hABCD,  4'd3, 16'hABCD, 1'b1};
        vecs[14] = '{3'd1, 16'hFFFF,  4'd0, 16'hFFFF, 1'b0};

        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_zero", out_zero, 1);
        check("rst_out_err", out_err, 0);
        #19 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Directed vectors, one at a time through an empty pipe.
        foreach (vecs[i]) begin
            run_one(vecs[i].mode, vecs[i].data, vecs[i].shamt, od, oe, oz, lat);
            check($sformatf("v%0d_data", i), od, vecs[i].exp_data);
            check($sformatf("v%0d_err", i), oe, vecs[i].exp_err);
            check($sformatf("v%0d_zero", i), oz, vecs[i].exp_data == 0);
            check($sformatf("v%0d_latency", i), lat, SW);
        end

        // Backpressure: with out_ready low only SW operands fit.
        for (int i = 0; i < 6; i++) begin
            bp_mode[i]  = 3'($urandom_range(0, 4));
            bp_data[i]  = W'($urandom);
            bp_shamt[i] = SW'($urandom_range(0, W - 1));
        end
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_mode  = bp_mode[idx];
            in_data  = bp_data[idx];
            in_shamt = bp_shamt[idx];
            cycle(acc);
            if (acc) idx++;
        end
        check("bp_accepted", idx, SW);
        check("bp_in_ready_low", in_ready, 0);

        // Release: simultaneous emit and accept, then 1 result per cycle.
        out_ready = 1'b1;
        #1;
        check("bp_full_in_ready", in_ready, 1);
        base = out_cnt;
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 6);
            if (idx < 6) begin
                in_mode  = bp_mode[idx];
                in_data  = bp_data[idx];
                in_shamt = bp_shamt[idx];
            end
            cycle(acc);
            if (acc) idx++;
        end
        check("bp_all_accepted", idx, 6);
        check("bp_out_rate", out_cnt - base, 6);
        check("bp_queue_empty", exp_q.size(), 0);

        // Random bubbles on both sides against the reference model.
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            rand_op();
            cycle(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) cycle(acc);
        check("rand_drain_empty", exp_q.size(), 0);

        // Reset with three operands in flight.
        out_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 10 && n < 3; c++) begin
            in_valid = 1'b1;
            in_mode  = 3'd0;
            in_data  = 16'h00F0 + 16'(c);
            in_shamt = 4'd2;
            cycle(acc);
            if (acc) n++;
        end
        in_valid = 1'b0;
        cycle(acc);
        check("pre_reset_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_zero", out_zero, 1);
        exp_q.delete();
        prev_hold = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        run_one(3'd4, 16'h0001, 4'd4, od, oe, oz, lat);
        check("post_rst_data", od, 16'h1000);
        check("post_rst_err", oe, 0);
        check("post_rst_latency", lat, SW);
        base = out_cnt;
        for (int c = 0; c < 8; c++) cycle(acc);
        check("post_rst_no_stale", out_cnt - base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
